display_scan_mux: RTL

Time-multiplexed driver for the board's two-digit seven-segment display. It sits directly downstream of the binary-to-seven-segment display stage and consumes its `seg_tens`/`seg_ones` codes. It drives one shared segment bus plus two digit enables. It alternates digits at a programmable rate and inserts a blanking (dead) interval between digits to suppress ghosting. Each digit's code is snapshotted at the start of its on-time so the output cannot glitch mid-digit.

---
 rtl/display_scan_mux_pkg.sv | 24 ++
 rtl/display_scan_mux_timer.sv | 27 ++
 rtl/display_scan_mux.sv | 93 +++++++++
 3 files changed

// File: rtl/display_scan_mux_pkg.sv
// Shared types and constants for the seven-segment display scan blocks.
package display_scan_mux_pkg;

  typedef enum logic [1:0] {
    DEAD_T = 2'd0,
    ONES   = 2'd1,
    DEAD_O = 2'd2,
    TENS   = 2'd3
  } scan_state_t;

  localparam logic [1:0] AN_OFF    = 2'b00;
  localparam logic [1:0] AN_ONES   = 2'b01;
  localparam logic [1:0] AN_TENS   = 2'b10;
  localparam logic [6:0] SEG_BLANK = 7'b0;

  // Phase counter width: must hold the longest phase, and never collapse to 0 bits.
  function automatic int cnt_width(input int digit_cycles, input int dead_cycles);
    int m;
    m = (digit_cycles > dead_cycles) ? digit_cycles : dead_cycles;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/display_scan_mux_timer.sv
// Phase counter for the display scan: counts 0..last, flags terminal count, wraps to 0.
// tc is combinational from the count; clr zeroes the count on the next edge.
module display_scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Two-digit seven-segment scan driver with dead-time blanking and per-digit snapshot.
// Outputs decode registered state only; en low blanks on the next edge.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int DEAD_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_tens,
  input  logic [6:0] seg_ones,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int         W         = cnt_width(DIGIT_CYCLES, DEAD_CYCLES);
  localparam logic [W-1:0] DIG_LAST  = W'(DIGIT_CYCLES - 1);
  localparam logic [W-1:0] DEAD_LAST = W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam bit         NO_DEAD   = (DEAD_CYCLES == 0);

  scan_state_t  state;
  scan_state_t  nxt;
  logic [6:0]   snap;
  logic [W-1:0] last;
  logic         tc;

  assign last = (state == ONES || state == TENS) ? DIG_LAST : DEAD_LAST;

  display_scan_timer #(.W(W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!en),
    .last (last),
    .tc   (tc)
  );

  // With no dead time, DEAD_T is only ever seen as the one-cycle post-reset state.
  always_comb begin
    nxt = state;
    case (state)
      DEAD_T:  nxt = ONES;
      ONES:    nxt = NO_DEAD ? TENS : DEAD_O;
      DEAD_O:  nxt = TENS;
      TENS:    nxt = NO_DEAD ? ONES : DEAD_T;
      default: nxt = DEAD_T;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DEAD_T;
      snap  <= SEG_BLANK;
      frame <= 1'b0;
    end else if (!en) begin
      state <= DEAD_T;
      snap  <= SEG_BLANK;
      frame <= 1'b0;
    end else begin
      frame <= tc && (state == TENS);
      if (tc) begin
        state <= nxt;
        if (nxt == ONES) begin
          snap <= seg_ones;
        end else if (nxt == TENS) begin
          snap <= seg_tens;
        end
      end
    end
  end

  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    case (state)
      ONES: begin
        an  = AN_ONES;
        seg = snap;
      end
      TENS: begin
        an  = AN_TENS;
        seg = snap;
      end
      default: begin
        an  = AN_OFF;
        seg = SEG_BLANK;
      end
    endcase
  end

endmodule
